hrr_sched_pipe: RTL

//  Two-level hierarchical round-robin scheduler: GROUPS x GROUP_W requesters, one grant per cycle.
//  A top PPE arbitrates among non-empty groups; one inner PPE per group arbitrates within it.

---
 rtl/hrr_sched_pipe.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/hrr_sched_pipe.sv
// rtl/hrr_sched_pipe.sv - two-level hierarchical round-robin scheduler, registered, valid/ready grant
//
// GROUPS x GROUP_W requesters. A top round-robin picks among non-empty groups, an inner
// round-robin per group picks the requester. Requests are registered (stage 1), picked
// combinationally from the registered copy (stage 2), and the pick lands in the output
// register. Pointers move only when a grant is accepted.
//
// Optional feature macro: SCHED_STATS_EN (per-group saturating accepted-grant counters).
//
// Ports:
//   clk        clock, posedge
//   rst_n      asynchronous active-low reset
//   req        request vector, bit g*GROUP_W+i = requester i of group g
//   gnt_valid  grant present on gnt/gnt_idx
//   gnt_ready  consumer accepts the grant this cycle
//   gnt        one-hot grant, zero when gnt_valid=0
//   gnt_idx    {group, index} of the granted requester, zero when gnt_valid=0
//   stat_sel   group selector for counter readout      (SCHED_STATS_EN)
//   stat_cnt   accepted-grant count of group stat_sel  (SCHED_STATS_EN)

module hrr_sched_pipe #(
    parameter int GROUPS  = 8,
    parameter int GROUP_W = 8,
    parameter int G_LOG   = 3,
    parameter int W_LOG   = 3
`ifdef SCHED_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [GROUPS*GROUP_W-1:0]  req,
    output logic                       gnt_valid,
    input  logic                       gnt_ready,
    output logic [GROUPS*GROUP_W-1:0]  gnt,
    output logic [G_LOG+W_LOG-1:0]     gnt_idx
`ifdef SCHED_STATS_EN
    ,
    input  logic [G_LOG-1:0]           stat_sel,
    output logic [CNT_W-1:0]           stat_cnt
`endif
);

    logic [GROUPS*GROUP_W-1:0] req_q;
    logic [G_LOG-1:0]          top_ptr;
    logic [G_LOG-1:0]          top_nxt;
    logic [W_LOG-1:0]          ptr     [GROUPS];
    logic [W_LOG-1:0]          ptr_nxt [GROUPS];

    logic                      advance;
    logic                      acc;
    logic [G_LOG-1:0]          acc_g;
    logic [W_LOG-1:0]          acc_i;
    logic [W_LOG-1:0]          acc_i_inc;
    logic                      acc_rest;

    logic [GROUPS-1:0]         grp_req;
    logic                      pick_any;
    logic [G_LOG-1:0]          top_pick;
    logic [G_LOG-1:0]          top_hi;
    logic                      top_hi_found;
    logic [GROUP_W-1:0]        pick_bits;
    logic [W_LOG-1:0]          pick_ptr;
    logic [W_LOG-1:0]          in_pick;
    logic [W_LOG-1:0]          in_hi;
    logic                      in_hi_found;
    logic [GROUPS*GROUP_W-1:0] gnt_d;
    logic [G_LOG+W_LOG-1:0]    idx_d;

    assign advance   = !gnt_valid || gnt_ready;
    assign acc       = gnt_valid && gnt_ready;
    assign acc_g     = gnt_idx[G_LOG+W_LOG-1 -: G_LOG];
    assign acc_i     = gnt_idx[W_LOG-1:0];
    assign acc_i_inc = (int'(acc_i) == GROUP_W-1) ? '0 : acc_i + W_LOG'(1);

    // Group occupancy, plus whether the accepted group still has requesters above the
    // granted index in this round (if not, the top pointer moves on).
    always_comb begin
        grp_req  = '0;
        acc_rest = 1'b0;
        for (int g = 0; g < GROUPS; g++) begin
            grp_req[g] = |req_q[g*GROUP_W +: GROUP_W];
            for (int i = 0; i < GROUP_W; i++) begin
                if (G_LOG'(g) == acc_g && i > int'(acc_i) && req_q[g*GROUP_W+i])
                    acc_rest = 1'b1;
            end
        end
    end

    // Pointer state after this cycle's accept. The pick below uses these values so that
    // back-to-back accepted grants never repeat a requester.
    always_comb begin
        top_nxt = top_ptr;
        if (acc) begin
            if (acc_rest)
                top_nxt = acc_g;
            else
                top_nxt = (int'(acc_g) == GROUPS-1) ? '0 : acc_g + G_LOG'(1);
        end
        for (int g = 0; g < GROUPS; g++)
            ptr_nxt[g] = (acc && G_LOG'(g) == acc_g) ? acc_i_inc : ptr[g];
    end

    // Top pick: lowest non-empty group at or above top_nxt, else lowest non-empty overall.
    // Scanning downward lets the last hit win, which is the lowest qualifying group.
    always_comb begin
        top_pick     = '0;
        top_hi       = '0;
        top_hi_found = 1'b0;
        for (int g = GROUPS-1; g >= 0; g--) begin
            if (grp_req[g]) begin
                top_pick = G_LOG'(g);
                if (g >= int'(top_nxt)) begin
                    top_hi       = G_LOG'(g);
                    top_hi_found = 1'b1;
                end
            end
        end
        if (top_hi_found)
            top_pick = top_hi;
    end

    always_comb begin
        pick_bits = '0;
        pick_ptr  = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (G_LOG'(g) == top_pick) begin
                pick_bits = req_q[g*GROUP_W +: GROUP_W];
                pick_ptr  = ptr_nxt[g];
            end
        end
    end

    // Inner pick, same circular scheme within the chosen group.
    always_comb begin
        in_pick     = '0;
        in_hi       = '0;
        in_hi_found = 1'b0;
        for (int i = GROUP_W-1; i >= 0; i--) begin
            if (pick_bits[i]) begin
                in_pick = W_LOG'(i);
                if (i >= int'(pick_ptr)) begin
                    in_hi       = W_LOG'(i);
                    in_hi_found = 1'b1;
                end
            end
        end
        if (in_hi_found)
            in_pick = in_hi;
    end

    assign pick_any = |grp_req;

    always_comb begin
        gnt_d = '0;
        idx_d = '0;
        if (pick_any) begin
            idx_d = {top_pick, in_pick};
            for (int g = 0; g < GROUPS; g++) begin
                for (int i = 0; i < GROUP_W; i++) begin
                    if (G_LOG'(g) == top_pick && W_LOG'(i) == in_pick)
                        gnt_d[g*GROUP_W+i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            gnt_valid <= 1'b0;
            gnt       <= '0;
            gnt_idx   <= '0;
            top_ptr   <= '0;
            for (int g = 0; g < GROUPS; g++)
                ptr[g] <= '0;
        end else begin
            if (advance) begin
                req_q     <= req;
                gnt_valid <= pick_any;
                gnt       <= gnt_d;
                gnt_idx   <= idx_d;
            end
            top_ptr <= top_nxt;
            for (int g = 0; g < GROUPS; g++)
                ptr[g] <= ptr_nxt[g];
        end
    end

`ifdef SCHED_STATS_EN
    logic [CNT_W-1:0] cnt [GROUPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < GROUPS; g++)
                cnt[g] <= '0;
        end else if (acc) begin
            for (int g = 0; g < GROUPS; g++) begin
                if (G_LOG'(g) == acc_g && cnt[g] != '1)
                    cnt[g] <= cnt[g] + CNT_W'(1);
            end
        end
    end

    // Selector values beyond the last group match nothing and read zero.
    always_comb begin
        stat_cnt = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (G_LOG'(g) == stat_sel)
                stat_cnt = cnt[g];
        end
    end
`endif

endmodule
